// File: rtl/ahb_lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb_lite_pkg
// Shared constants for the single-master AHB-Lite interconnect:
//   - HTRANS and HRESP encodings
//   - data-phase select encodings (slave index, default slave, nothing)
//   - state codes of the two-cycle ERROR sequencer
// ---------------------------------------------------------------------------
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Slave indices 0..15 occupy the low codes; the two top codes mark the
  // default slave and "no data phase in progress".
  typedef logic [4:0] dsel_t;
  localparam dsel_t DSEL_DFLT = 5'h1E;
  localparam dsel_t DSEL_NONE = 5'h1F;

  localparam logic [1:0] SEQ_IDLE = 2'd0;
  localparam logic [1:0] SEQ_ERR1 = 2'd1;
  localparam logic [1:0] SEQ_ERR2 = 2'd2;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY carry no data phase.
  function automatic logic trans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_err_seq.sv
// ---------------------------------------------------------------------------
// ahb_err_seq
// Two-cycle AHB ERROR response generator: IDLE -> ERR1 -> ERR2 -> IDLE.
// Ports:
//   HCLK, HRESET : clock, synchronous active-high reset
//   start        : begin an ERROR response on the next cycle
//   busy         : sequencer is in ERR1 or ERR2
//   hready       : 0 only in ERR1
//   hresp        : ERROR in ERR1/ERR2, OKAY otherwise
// ---------------------------------------------------------------------------
module ahb_err_seq
  import ahb_lite_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       start,
  output logic       busy,
  output logic       hready,
  output logic [1:0] hresp
);

  logic [1:0] state;

  // ERR2 is the cycle in which the master may issue a new address phase, so
  // a fresh start there chains straight into another ERROR response.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= SEQ_IDLE;
    end else begin
      case (state)
        SEQ_IDLE: state <= start ? SEQ_ERR1 : SEQ_IDLE;
        SEQ_ERR1: state <= SEQ_ERR2;
        SEQ_ERR2: state <= start ? SEQ_ERR1 : SEQ_IDLE;
        default:  state <= SEQ_IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (state == SEQ_ERR1) || (state == SEQ_ERR2);
    hready = (state != SEQ_ERR1);
    hresp  = busy ? HRESP_ERROR : HRESP_OKAY;
  end

endmodule

// File: rtl/ahb_lite_sn.sv
// ---------------------------------------------------------------------------
// ahb_lite_sn
// Single-master AHB-Lite interconnect for 1..16 slaves with address decode,
// REMAP swap, response multiplexer, built-in default (ERROR) slave and a
// stall watchdog that terminates hung transfers with ERROR.
// Ports:
//   HCLK, HRESET          : clock, synchronous active-high reset
//   M_*                   : master address/control/write data in,
//                           M_HRDATA/M_HRESP/M_HREADY back to master
//   S_HADDR..S_HWDATA     : master signals passed through to all slaves
//   S_HREADY              : copy of M_HREADY
//   S_HSEL                : one-hot (or zero) slave select
//   S_HREADYOUT/HRESP/HRDATA : packed per-slave responses
//   REMAP                 : swap slot 0 with slot P_REMAP_IDX
//   TO_CLR/TO_FLAG/TO_ADDR: watchdog flag clear, sticky flag, stalled address
// ---------------------------------------------------------------------------
module ahb_lite_sn
  import ahb_lite_pkg::*;
#(
  parameter int           P_NUM       = 4,
  parameter logic [511:0] P_START     = {16{32'h0}},
  parameter logic [511:0] P_SIZE      = {16{32'h0001_0000}},
  parameter int           P_REMAP_IDX = 1,
  parameter int           P_TIMEOUT   = 256
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [31:0]          M_HADDR,
  input  logic [1:0]           M_HTRANS,
  input  logic                 M_HWRITE,
  input  logic [2:0]           M_HSIZE,
  input  logic [2:0]           M_HBURST,
  input  logic [3:0]           M_HPROT,
  input  logic [31:0]          M_HWDATA,
  output logic [31:0]          M_HRDATA,
  output logic [1:0]           M_HRESP,
  output logic                 M_HREADY,
  output logic [31:0]          S_HADDR,
  output logic [1:0]           S_HTRANS,
  output logic                 S_HWRITE,
  output logic [2:0]           S_HSIZE,
  output logic [2:0]           S_HBURST,
  output logic [3:0]           S_HPROT,
  output logic [31:0]          S_HWDATA,
  output logic                 S_HREADY,
  output logic [P_NUM-1:0]     S_HSEL,
  input  logic [P_NUM-1:0]     S_HREADYOUT,
  input  logic [2*P_NUM-1:0]   S_HRESP,
  input  logic [32*P_NUM-1:0]  S_HRDATA,
  input  logic                 REMAP,
  input  logic                 TO_CLR,
  output logic                 TO_FLAG,
  output logic [31:0]          TO_ADDR
);

  // With a single slave there is nothing to swap; pointing the swap at slot 0
  // turns it into a no-op without extra conditions.
  localparam int REMAP_IDX = (P_NUM > 1) ? P_REMAP_IDX : 0;

  localparam int CW = (P_TIMEOUT < 1) ? 1 : $clog2(P_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = (P_TIMEOUT == 0) ? '0 : CW'(P_TIMEOUT - 1);

  logic [P_NUM-1:0] hit_raw;
  logic [P_NUM-1:0] hit_sw;
  dsel_t            asel;
  dsel_t            dsel;
  logic [31:0]      daddr;

  logic             slv_ready;
  logic [1:0]       slv_resp;
  logic [31:0]      slv_rdata;
  logic             dsel_real;

  logic             dflt_start;
  logic             dflt_busy;
  logic             dflt_hready;
  logic [1:0]       dflt_hresp;

  logic             wd_fire;
  logic             wd_busy;
  logic             wd_hready;
  logic [1:0]       wd_hresp;
  logic             stall;
  logic [CW-1:0]    cnt;

  assign S_HADDR  = M_HADDR;
  assign S_HTRANS = M_HTRANS;
  assign S_HWRITE = M_HWRITE;
  assign S_HSIZE  = M_HSIZE;
  assign S_HBURST = M_HBURST;
  assign S_HPROT  = M_HPROT;
  assign S_HWDATA = M_HWDATA;
  assign S_HREADY = M_HREADY;

  // Region compare in 33 bits so a region ending exactly at 2^32 is legal.
  always_comb begin
    logic [32:0] lo;
    logic [32:0] hi;
    lo      = '0;
    hi      = '0;
    hit_raw = '0;
    for (int i = 0; i < P_NUM; i++) begin
      lo = {1'b0, P_START[32*i +: 32]};
      hi = lo + {1'b0, P_SIZE[32*i +: 32]};
      hit_raw[i] = ({1'b0, M_HADDR} >= lo) && ({1'b0, M_HADDR} < hi);
    end
  end

  // REMAP exchanges the hits of slot 0 and the remap slot, then the lowest
  // hitting index wins so overlapping regions still give a one-hot select.
  always_comb begin
    hit_sw = hit_raw;
    if (REMAP) begin
      hit_sw[0]         = hit_raw[REMAP_IDX];
      hit_sw[REMAP_IDX] = hit_raw[0];
    end
    asel   = DSEL_DFLT;
    S_HSEL = '0;
    for (int i = P_NUM - 1; i >= 0; i--) begin
      if (hit_sw[i]) begin
        asel      = dsel_t'(i);
        S_HSEL    = '0;
        S_HSEL[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel  <= DSEL_NONE;
      daddr <= '0;
    end else if (M_HREADY) begin
      dsel  <= asel;
      daddr <= M_HADDR;
    end
  end

  // Pick the responding slave's raw outputs; dsel_real tells the watchdog and
  // the final mux that a real slave owns the data phase.
  always_comb begin
    slv_ready = 1'b1;
    slv_resp  = HRESP_OKAY;
    slv_rdata = '0;
    dsel_real = 1'b0;
    for (int i = 0; i < P_NUM; i++) begin
      if (dsel == dsel_t'(i)) begin
        slv_ready = S_HREADYOUT[i];
        slv_resp  = S_HRESP[2*i +: 2];
        slv_rdata = S_HRDATA[32*i +: 32];
        dsel_real = 1'b1;
      end
    end
  end

  // The watchdog override takes precedence over everything, slave outputs
  // included, until its ERROR response has been delivered.
  always_comb begin
    if (wd_busy) begin
      M_HREADY = wd_hready;
      M_HRESP  = wd_hresp;
      M_HRDATA = '0;
    end else if (dsel_real) begin
      M_HREADY = slv_ready;
      M_HRESP  = slv_resp;
      M_HRDATA = slv_rdata;
    end else if (dsel == DSEL_DFLT) begin
      M_HREADY = dflt_hready;
      M_HRESP  = dflt_hresp;
      M_HRDATA = '0;
    end else begin
      M_HREADY = 1'b1;
      M_HRESP  = HRESP_OKAY;
      M_HRDATA = '0;
    end
  end

  assign dflt_start = (asel == DSEL_DFLT) && M_HREADY && trans_active(M_HTRANS);

  ahb_err_seq u_dflt (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .start  (dflt_start),
    .busy   (dflt_busy),
    .hready (dflt_hready),
    .hresp  (dflt_hresp)
  );

  // A stall is a real slave holding HREADYOUT low in the data phase. The
  // final stall cycle is the one where cnt already equals P_TIMEOUT-1.
  assign stall   = dsel_real && !slv_ready;
  assign wd_fire = (P_TIMEOUT != 0) && !wd_busy && stall && (cnt == CNT_LAST);

  // Counter saturates rather than wrapping, and is held at zero while the
  // override runs so a stale count cannot leak into the next transfer.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt <= '0;
    end else if (wd_fire || wd_busy || !stall) begin
      cnt <= '0;
    end else if (cnt != CNT_LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  ahb_err_seq u_wd (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .start  (wd_fire),
    .busy   (wd_busy),
    .hready (wd_hready),
    .hresp  (wd_hresp)
  );

  // Set has priority over clear so a timeout is never lost to a late TO_CLR.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      TO_FLAG <= 1'b0;
      TO_ADDR <= '0;
    end else begin
      if (wd_fire) begin
        TO_FLAG <= 1'b1;
        TO_ADDR <= daddr;
      end else if (TO_CLR) begin
        TO_FLAG <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_sn.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_sn
// Directed bench for ahb_lite_sn: four 64 KiB slots at 0x0000_0000,
// 0x1000_0000, 0x2000_0000 and 0x3000_0000, remap slot 1, watchdog of 8.
// ---------------------------------------------------------------------------
module tb_ahb_lite_sn;
  import ahb_lite_pkg::*;

  localparam int           NUM     = 4;
  localparam int           TIMEOUT = 8;
  localparam logic [511:0] START   = {{12{32'h0}}, 32'h3000_0000, 32'h2000_0000,
                                      32'h1000_0000, 32'h0000_0000};
  localparam logic [511:0] SIZE    = {16{32'h0001_0000}};

  logic                HCLK = 1'b0;
  logic                HRESET;
  logic [31:0]         M_HADDR;
  logic [1:0]          M_HTRANS;
  logic                M_HWRITE;
  logic [2:0]          M_HSIZE;
  logic [2:0]          M_HBURST;
  logic [3:0]          M_HPROT;
  logic [31:0]         M_HWDATA;
  logic [31:0]         M_HRDATA;
  logic [1:0]          M_HRESP;
  logic                M_HREADY;
  logic [31:0]         S_HADDR;
  logic [1:0]          S_HTRANS;
  logic                S_HWRITE;
  logic [2:0]          S_HSIZE;
  logic [2:0]          S_HBURST;
  logic [3:0]          S_HPROT;
  logic [31:0]         S_HWDATA;
  logic                S_HREADY;
  logic [NUM-1:0]      S_HSEL;
  logic [NUM-1:0]      S_HREADYOUT;
  logic [2*NUM-1:0]    S_HRESP;
  logic [32*NUM-1:0]   S_HRDATA;
  logic                REMAP;
  logic                TO_CLR;
  logic                TO_FLAG;
  logic [31:0]         TO_ADDR;

  int checkCount = 0;
  int errorCount = 0;

  ahb_lite_sn #(
    .P_NUM       (NUM),
    .P_START     (START),
    .P_SIZE      (SIZE),
    .P_REMAP_IDX (1),
    .P_TIMEOUT   (TIMEOUT)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .M_HADDR     (M_HADDR),
    .M_HTRANS    (M_HTRANS),
    .M_HWRITE    (M_HWRITE),
    .M_HSIZE     (M_HSIZE),
    .M_HBURST    (M_HBURST),
    .M_HPROT     (M_HPROT),
    .M_HWDATA    (M_HWDATA),
    .M_HRDATA    (M_HRDATA),
    .M_HRESP     (M_HRESP),
    .M_HREADY    (M_HREADY),
    .S_HADDR     (S_HADDR),
    .S_HTRANS    (S_HTRANS),
    .S_HWRITE    (S_HWRITE),
    .S_HSIZE     (S_HSIZE),
    .S_HBURST    (S_HBURST),
    .S_HPROT     (S_HPROT),
    .S_HWDATA    (S_HWDATA),
    .S_HREADY    (S_HREADY),
    .S_HSEL      (S_HSEL),
    .S_HREADYOUT (S_HREADYOUT),
    .S_HRESP     (S_HRESP),
    .S_HRDATA    (S_HRDATA),
    .REMAP       (REMAP),
    .TO_CLR      (TO_CLR),
    .TO_FLAG     (TO_FLAG),
    .TO_ADDR     (TO_ADDR)
  );

  // 10 ns clock; all stimulus changes 1 ns after the rising edge.
  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and present a new address phase.
  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans,
                               input logic write);
    @(posedge HCLK);
    #1;
    M_HADDR  = addr;
    M_HTRANS = trans;
    M_HWRITE = write;
  endtask

  // Let combinational outputs settle before sampling mid-cycle.
  task automatic settle();
    #4;
  endtask

  // Issue a NONSEQ read to slave 1 while it holds HREADYOUT low, then walk
  // through the given number of stall cycles checking HREADY stays low.
  task automatic stallSlave1(input logic [31:0] addr, input int cycles);
    applyStimulus(addr, HTRANS_NONSEQ, 1'b0);
    S_HREADYOUT = 4'b1101;
    settle();
    checkOutput("wd_hsel", 32'(S_HSEL), 32'h2);
    for (int k = 1; k <= cycles; k++) begin
      applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
      settle();
      checkOutput($sformatf("wd_stall%0d_hready", k), 32'(M_HREADY), 32'h0);
    end
  endtask

  initial begin
    HRESET      = 1'b1;
    M_HADDR     = 32'h0;
    M_HTRANS    = HTRANS_IDLE;
    M_HWRITE    = 1'b0;
    M_HSIZE     = 3'b010;
    M_HBURST    = 3'b000;
    M_HPROT     = 4'b0011;
    M_HWDATA    = 32'hCAFE_0001;
    S_HREADYOUT = 4'b1111;
    S_HRESP     = '0;
    S_HRDATA    = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0000};
    REMAP       = 1'b0;
    TO_CLR      = 1'b0;

    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    settle();
    checkOutput("rst_hready", 32'(M_HREADY), 32'h1);
    checkOutput("rst_hresp",  32'(M_HRESP),  32'h0);
    checkOutput("rst_hrdata", M_HRDATA,      32'h0);
    checkOutput("rst_toflag", 32'(TO_FLAG),  32'h0);
    checkOutput("rst_toaddr", TO_ADDR,       32'h0);

    // Zero-wait read from slot 2.
    applyStimulus(32'h2000_0010, HTRANS_NONSEQ, 1'b0);
    settle();
    checkOutput("rd_hsel",  32'(S_HSEL), 32'h4);
    checkOutput("rd_haddr", S_HADDR,     32'h2000_0010);
    applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
    settle();
    checkOutput("rd_hrdata", M_HRDATA,      32'hDEAD_BEEF);
    checkOutput("rd_hresp",  32'(M_HRESP),  32'h0);
    checkOutput("rd_hready", 32'(M_HREADY), 32'h1);

    // REMAP swaps slots 0 and 1 in both directions.
    applyStimulus(32'h0000_0004, HTRANS_NONSEQ, 1'b1);
    REMAP = 1'b1;
    settle();
    checkOutput("remap_slot0_hsel", 32'(S_HSEL), 32'h2);
    applyStimulus(32'h1000_0000, HTRANS_NONSEQ, 1'b0);
    settle();
    checkOutput("remap_slot1_hsel", 32'(S_HSEL), 32'h1);
    applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
    REMAP = 1'b0;
    settle();
    checkOutput("noremap_hsel", 32'(S_HSEL), 32'h1);

    // Unmapped NONSEQ goes through the two-cycle default-slave ERROR.
    applyStimulus(32'h9000_0000, HTRANS_NONSEQ, 1'b0);
    settle();
    checkOutput("dflt_hsel", 32'(S_HSEL), 32'h0);
    applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
    settle();
    checkOutput("dflt_err1_hready", 32'(M_HREADY), 32'h0);
    checkOutput("dflt_err1_hresp",  32'(M_HRESP),  32'h1);
    @(posedge HCLK);
    #1;
    settle();
    checkOutput("dflt_err2_hready", 32'(M_HREADY), 32'h1);
    checkOutput("dflt_err2_hresp",  32'(M_HRESP),  32'h1);
    applyStimulus(32'h9000_0000, HTRANS_IDLE, 1'b0);
    settle();
    applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
    settle();
    checkOutput("dflt_idle_hready", 32'(M_HREADY), 32'h1);
    checkOutput("dflt_idle_hresp",  32'(M_HRESP),  32'h0);
    checkOutput("dflt_idle_hrdata", M_HRDATA,      32'h0);

    // Watchdog: eight stall cycles, then TERR1 and TERR2.
    stallSlave1(32'h1000_0040, TIMEOUT);
    applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
    settle();
    checkOutput("terr1_hready", 32'(M_HREADY), 32'h0);
    checkOutput("terr1_hresp",  32'(M_HRESP),  32'h1);
    checkOutput("terr1_toflag", 32'(TO_FLAG),  32'h1);
    checkOutput("terr1_toaddr", TO_ADDR,       32'h1000_0040);
    applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
    settle();
    checkOutput("terr2_hready", 32'(M_HREADY), 32'h1);
    checkOutput("terr2_hresp",  32'(M_HRESP),  32'h1);
    applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
    S_HREADYOUT = 4'b1111;
    settle();
    checkOutput("post_to_hready", 32'(M_HREADY), 32'h1);
    checkOutput("post_to_hresp",  32'(M_HRESP),  32'h0);
    checkOutput("post_to_toflag", 32'(TO_FLAG),  32'h1);
    applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
    TO_CLR = 1'b1;
    settle();
    checkOutput("toclr_pending_toflag", 32'(TO_FLAG), 32'h1);
    applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
    TO_CLR = 1'b0;
    settle();
    checkOutput("toclr_toflag", 32'(TO_FLAG), 32'h0);
    checkOutput("toclr_toaddr", TO_ADDR,      32'h1000_0040);

    // Ready arrives on the eighth stall cycle: normal completion.
    stallSlave1(32'h1000_0080, TIMEOUT - 1);
    applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
    S_HREADYOUT = 4'b1111;
    settle();
    checkOutput("late_hready", 32'(M_HREADY), 32'h1);
    checkOutput("late_hresp",  32'(M_HRESP),  32'h0);
    checkOutput("late_hrdata", M_HRDATA,      32'h1111_1111);
    applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
    settle();
    checkOutput("late_toflag", 32'(TO_FLAG), 32'h0);
    checkOutput("late_next_hresp", 32'(M_HRESP), 32'h0);

    // Reset asserted during TERR1 abandons the transfer.
    stallSlave1(32'h1000_00C0, TIMEOUT);
    applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
    HRESET = 1'b1;
    settle();
    checkOutput("rterr1_hready", 32'(M_HREADY), 32'h0);
    checkOutput("rterr1_toflag", 32'(TO_FLAG),  32'h1);
    applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
    HRESET      = 1'b0;
    S_HREADYOUT = 4'b1111;
    settle();
    checkOutput("rst_terr1_hready", 32'(M_HREADY), 32'h1);
    checkOutput("rst_terr1_hresp",  32'(M_HRESP),  32'h0);
    checkOutput("rst_terr1_toflag", 32'(TO_FLAG),  32'h0);
    checkOutput("rst_terr1_toaddr", TO_ADDR,       32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
